// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder: FSM encoding, bus
// direction codes and the address-window decode.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Lower bound is tested first, so the subtraction never wraps.
  function automatic logic win_sel(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] depth);
    return (addr >= base) && ((addr - base) < depth);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x 64 word storage: one synchronous write port and one registered
// read port. Only the read register is reset; the contents are not.
module mem_responder_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rclr returns zero for a read that missed the window
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = rclr ? 64'd0 : mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= 64'd0;
    else        rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: window decode, wait-state FSM, access latch and
// loader arbitration in front of the word storage array.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          AW          = 8,
  parameter logic [63:0] BASE        = 64'd0,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   address,
  input  logic          rw,
  input  logic [63:0]   datao,
  output logic [63:0]   data,
  output logic          ready,
  output logic          err,
  output logic          busy,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [63:0]   load_data
);

  localparam logic [63:0] DEPTH64 = 64'(DEPTH);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic          sel_in;
  logic [AW-1:0] idx_in;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [63:0]   mem_wdata;
  logic          rd_en, rd_clr;
  logic [AW-1:0] rd_addr;

  assign sel_in = win_sel(address, BASE, DEPTH64);
  assign idx_in = AW'(address - BASE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    rd_en     = 1'b0;
    rd_clr    = 1'b0;
    rd_addr   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          mem_we = 1'b1;
        end else begin
          rw_d    = rw;
          sel_d   = sel_in;
          idx_d   = idx_in;
          wdata_d = datao;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            // zero wait states: read straight from the live bus index
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = ~sel_in;
            rd_en   = (rw == RW_READ);
            rd_clr  = ~sel_in;
            rd_addr = idx_in;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = ~sel_q;
          rd_en   = (rw_q == RW_READ);
          rd_clr  = ~sel_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (rw_q == RW_WRITE && sel_q) begin
          mem_we    = 1'b1;
          mem_waddr = idx_q;
          mem_wdata = wdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_READ;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 64'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset, so block writes while reset is held.
  mem_responder_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we & reset),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_en),
    .rclr  (rd_clr),
    .raddr (rd_addr),
    .rdata (data)
  );

  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (BASE=0/WS=0 and BASE=0x100/WS=3) driven
// by directed accesses; a monitor checks every ready pulse against the queue.
module tb_mem_responder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    int          dut;
    logic [63:0] data;
    logic        err;
    int          issue;
    int          pitch;
  } exp_t;

  logic                 clk;
  logic [1:0]           rst_n;
  logic [1:0][63:0]     address, datao, load_data, data;
  logic [1:0]           rw, load_en, ready, err, busy;
  logic [1:0][AW-1:0]   load_addr;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          nchecks = 0;
  int          nerr = 0;
  int          last_rdy [2];
  logic [63:0] last_rd [2];

  mem_responder #(.DEPTH(DEPTH), .AW(AW), .BASE(64'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .address(address[0]), .rw(rw[0]), .datao(datao[0]),
    .data(data[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
  );

  mem_responder #(.DEPTH(DEPTH), .AW(AW), .BASE(64'h100), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .address(address[1]), .rw(rw[1]), .datao(datao[1]),
    .data(data[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Idle filler: loader rewrites scratch word DEPTH-1 with 0, keeping the FSM in IDLE.
  task automatic filler(input int k);
    load_en[k]   = 1'b1;
    load_addr[k] = AW'(DEPTH - 1);
    load_data[k] = 64'd0;
    rw[k]        = 1'b1;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[k] && n < 50);
    if (busy[k]) begin
      nchecks++;
      nerr++;
      $display("FAIL idle_timeout dut%0d: busy still 1 after %0d cycles", k, n);
    end
  endtask

  task automatic load(input int k, input int idx, input logic [63:0] val);
    wait_idle(k);
    load_en[k]   = 1'b1;
    load_addr[k] = AW'(idx);
    load_data[k] = val;
    @(posedge clk);
    #1 filler(k);
  endtask

  // Issue one bus access; a write expects data to hold the last read value.
  task automatic access(input int k, input logic [63:0] a, input logic r,
                        input logic [63:0] wd, input logic [63:0] ed, input logic ee,
                        input int pitch, input bit expect_it);
    exp_t e;
    wait_idle(k);
    address[k] = a;
    rw[k]      = r;
    datao[k]   = wd;
    load_en[k] = 1'b0;
    if (r) last_rd[k] = ed;
    e.dut   = k;
    e.data  = last_rd[k];
    e.err   = ee;
    e.issue = cyc + 1;
    e.pitch = pitch;
    if (expect_it) sb.push_back(e);
    @(posedge clk);
    #1 filler(k);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ready[k] === 1'b1) begin
        if (sb.size() == 0 || sb[0].dut != k) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_ready dut%0d: ready=1 at cycle %0d, no access expected", k, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("data dut%0d", k), data[k], mon_e.data);
          chk($sformatf("err dut%0d", k), 64'(err[k]), 64'(mon_e.err));
          chk($sformatf("latency dut%0d", k), 64'(cyc - mon_e.issue), 64'(ws_of(k)));
          if (mon_e.pitch != 0)
            chk($sformatf("pitch dut%0d", k), 64'(cyc - last_rdy[k]), 64'(mon_e.pitch));
        end
        last_rdy[k] = cyc;
      end
    end
  end

  initial begin
    int n;
    int bcnt;
    rst_n = 2'b00;
    address = '0; datao = '0;
    last_rd[0] = 64'd0; last_rd[1] = 64'd0;
    last_rdy[0] = 0; last_rdy[1] = 0;
    filler(0); filler(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready dut%0d", k), 64'(ready[k]), 64'd0);
      chk($sformatf("rst_busy dut%0d", k), 64'(busy[k]), 64'd0);
    end
    rst_n = 2'b11;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_rst_data dut%0d", k), data[k], 64'd0);
      chk($sformatf("post_rst_ready dut%0d", k), 64'(ready[k]), 64'd0);
      chk($sformatf("post_rst_busy dut%0d", k), 64'(busy[k]), 64'd0);
    end

    for (int k = 0; k < 2; k++) begin
      load(k, 0, 64'h11); load(k, 1, 64'h22); load(k, 2, 64'h33); load(k, 3, 64'h44);
    end

    // dut0, zero wait states
    access(0, 64'd2, 1'b1, 64'd0, 64'h33, 1'b0, 0, 1'b1);
    access(0, 64'd7, 1'b0, 64'h77, 64'd0, 1'b0, 0, 1'b1);
    access(0, 64'd7, 1'b1, 64'd0, 64'h77, 1'b0, 2, 1'b1);
    access(0, 64'd16, 1'b1, 64'd0, 64'd0, 1'b1, 2, 1'b1);
    // loader and read request in the same IDLE cycle
    wait_idle(0);
    load_en[0] = 1'b1; load_addr[0] = AW'(6); load_data[0] = 64'h66;
    address[0] = 64'd6; rw[0] = 1'b1;
    @(posedge clk);
    #1 chk("arb_busy dut0", 64'(busy[0]), 64'd0);
    access(0, 64'd6, 1'b1, 64'd0, 64'h66, 1'b0, 0, 1'b1);

    // dut1, BASE=0x100, three wait states
    access(1, 64'h105, 1'b0, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 0, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy[1]) bcnt++;
    end
    chk("busy_cycles dut1", 64'(bcnt), 64'd4);
    access(1, 64'h105, 1'b1, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 5, 1'b1);
    access(1, 64'hFF, 1'b1, 64'd0, 64'd0, 1'b1, 5, 1'b1);
    access(1, 64'h102, 1'b1, 64'd0, 64'h33, 1'b0, 5, 1'b1);
    access(1, 64'h110, 1'b0, 64'hBAD, 64'd0, 1'b1, 5, 1'b1);
    access(1, 64'h100, 1'b1, 64'd0, 64'h11, 1'b0, 5, 1'b1);
    access(1, 64'h10F, 1'b1, 64'd0, 64'd0, 1'b0, 5, 1'b1);

    // bus changes during WAIT must not affect the latched access
    access(1, 64'h102, 1'b1, 64'd0, 64'h33, 1'b0, 5, 1'b1);
    address[1] = 64'h103; rw[1] = 1'b0; datao[1] = 64'hBADBAD; load_en[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    filler(1);
    access(1, 64'h103, 1'b1, 64'd0, 64'h44, 1'b0, 5, 1'b1);

    // reset during the WAIT of a write
    access(1, 64'h101, 1'b0, 64'h99, 64'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("midrst_ready dut1", 64'(ready[1]), 64'd0);
    chk("midrst_err dut1", 64'(err[1]), 64'd0);
    chk("midrst_busy dut1", 64'(busy[1]), 64'd0);
    chk("midrst_data dut1", data[1], 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    last_rd[1] = 64'd0;
    access(1, 64'h101, 1'b1, 64'd0, 64'h22, 1'b0, 0, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      nchecks++;
      nerr++;
      $display("FAIL drain: %0d responses still outstanding, 0 required", sb.size());
    end
    repeat (6) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
